// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the execute stage and the data RAM.
//
// Takes one memory instruction per req_valid/req_ready handshake and forms the
// effective address ea = base + offset (32-bit, wrapping). It then checks
// legality, alignment and range, pulses a single RAM strobe, and returns
// exactly one response. That response is load data, a store completion, or an
// exception record.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_*             request from execute (valid/ready handshake, IDLE only)
//   ram_load/store    one-cycle RAM strobes, only ever in ISSUE
//   ram_access/addr/wdata  driven from the latched request in every state
//   ram_rdata         extended read data, valid one cycle after ram_load
//   resp_*            one-cycle response pulse (no backpressure)
//
// Parameters
//   MEM_BYTES         RAM size in bytes; addresses >= MEM_BYTES fault
module lsu_ctrl #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_exc,
  output logic [3:0]  resp_cause
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Range limit widened by one bit so the comparison stays unsigned and exact.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  state_t      state;
  logic        lat_load;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_base;
  logic [31:0] lat_offset;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd;

  logic [31:0] ea;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [3:0]  fault_cause;

  // Exactly one of load/store must be set, and funct3 must name an access
  // width/extension that the operation supports.
  function automatic logic is_illegal(input logic ld, input logic st,
                                      input logic [2:0] f3);
    logic bad;
    if (ld == st)
      bad = 1'b1;
    else if (ld)
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else
      bad = f3[2] || (f3[1:0] == 2'b11);
    return bad;
  endfunction

  // Halfword needs ea[0]=0; word needs ea[1:0]=0. Byte accesses always align.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lsb);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lsb[0];
      2'b10:   mis = (lsb != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  assign ea           = lat_base + lat_offset;
  assign illegal      = is_illegal(lat_load, lat_store, lat_funct3);
  assign misaligned   = is_misaligned(lat_funct3, ea[1:0]);
  assign out_of_range = ({1'b0, ea} >= MEM_LIMIT);
  assign fault        = illegal || misaligned || out_of_range;

  // Priority: illegal, then misaligned, then access fault.
  always_comb begin
    fault_cause = 4'd0;
    if (illegal)
      fault_cause = CAUSE_ILLEGAL;
    else if (misaligned)
      fault_cause = lat_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
    else if (out_of_range)
      fault_cause = lat_load ? CAUSE_LD_ACCESS : CAUSE_ST_ACCESS;
  end

  assign ram_addr   = ea;
  assign ram_access = lat_funct3;
  assign ram_wdata  = lat_wdata;

  // Strobes are decoded from state so they cover exactly the ISSUE cycle.
  // Gating with rst keeps a reset in that cycle from touching the RAM. A
  // legal request has exactly one of load/store set, so the two never overlap.
  assign ram_load  = (state == ISSUE) && !rst && !fault && lat_load;
  assign ram_store = (state == ISSUE) && !rst && !fault && lat_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_cause <= 4'd0;
      resp_rd    <= 5'd0;
      resp_data  <= 32'd0;
      lat_load   <= 1'b0;
      lat_store  <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_base   <= 32'd0;
      lat_offset <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_rd     <= 5'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        // IDLE: accept and latch the request.
        IDLE: begin
          if (req_valid) begin
            lat_load   <= req_load;
            lat_store  <= req_store;
            lat_funct3 <= req_funct3;
            lat_base   <= req_base;
            lat_offset <= req_offset;
            lat_wdata  <= req_wdata;
            lat_rd     <= req_rd;
            req_ready  <= 1'b0;
            state      <= ISSUE;
          end
        end
        // ISSUE: strobe fires combinationally; prepare the response fields.
        ISSUE: begin
          resp_exc   <= 1'b0;
          resp_cause <= 4'd0;
          resp_rd    <= 5'd0;
          resp_data  <= 32'd0;
          if (fault) begin
            resp_exc   <= 1'b1;
            resp_cause <= fault_cause;
            resp_data  <= ea;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (lat_store) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        // WAIT: RAM read data is valid this cycle.
        WAIT: begin
          resp_data  <= ram_rdata;
          resp_rd    <= lat_rd;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // RESP: response is presented for this single cycle.
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed requests against a small byte-addressed RAM
// model, with expected responses queued at issue and checked on resp_valid.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        ram_load;
  logic        ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic [3:0]  resp_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_BYTES(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .ram_load   (ram_load),
    .ram_store  (ram_store),
    .ram_access (ram_access),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .resp_valid (resp_valid),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .resp_exc   (resp_exc),
    .resp_cause (resp_cause)
  );

  // RAM model: little-endian bytes, extension done here as the real RAM does.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = ram_addr[11:0];

  always @(posedge clk) begin
    if (ram_store) begin
      mem[ma] <= ram_wdata[7:0];
      if (ram_access[1:0] != 2'b00) mem[ma + 12'd1] <= ram_wdata[15:8];
      if (ram_access[1:0] == 2'b10) begin
        mem[ma + 12'd2] <= ram_wdata[23:16];
        mem[ma + 12'd3] <= ram_wdata[31:24];
      end
    end
    if (ram_load) begin
      case (ram_access)
        3'b000:  ram_rdata <= {{24{mem[ma][7]}}, mem[ma]};
        3'b100:  ram_rdata <= {24'd0, mem[ma]};
        3'b001:  ram_rdata <= {{16{mem[ma + 12'd1][7]}}, mem[ma + 12'd1], mem[ma]};
        3'b101:  ram_rdata <= {16'd0, mem[ma + 12'd1], mem[ma]};
        default: ram_rdata <= {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
      endcase
    end
  end

  // kind: 0 no strobe expected (fault), 1 load, 2 store.
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic        exc;
    logic [3:0]  cause;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t e_store(input logic [31:0] addr);
    exp_t e;
    e.kind = 2'd2; e.addr = addr; e.exc = 1'b0; e.cause = 4'd0;
    e.rd = 5'd0; e.data = 32'd0; e.lat = 2;
    return e;
  endfunction

  function automatic exp_t e_load(input logic [31:0] addr, input logic [4:0] rd,
                                  input logic [31:0] data);
    exp_t e;
    e.kind = 2'd1; e.addr = addr; e.exc = 1'b0; e.cause = 4'd0;
    e.rd = rd; e.data = data; e.lat = 3;
    return e;
  endfunction

  function automatic exp_t e_fault(input logic [3:0] cause, input logic [31:0] ea);
    exp_t e;
    e.kind = 2'd0; e.addr = ea; e.exc = 1'b1; e.cause = cause;
    e.rd = 5'd0; e.data = ea; e.lat = 2;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: handshake, strobe timing, response via scoreboard.
  task automatic run_req(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd,
                         input logic [4:0] rd, input exp_t e);
    int   cyc;
    int   nld;
    int   nst;
    bit   got;
    exp_t x;
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nld = 0; nst = 0; got = 1'b0;
    while (!got && cyc <= 10) begin
      if (ram_load)  nld++;
      if (ram_store) nst++;
      if (cyc == 1 && e.kind != 2'd0) chk({tag, ".ram_addr"}, ram_addr, e.addr);
      if (cyc == 1 && e.kind == 2'd2) chk({tag, ".ram_wdata"}, ram_wdata, wd);
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, ".got_resp"}, {31'd0, got}, 32'd1);
    x = sb.pop_front();
    chk({tag, ".latency"}, cyc, x.lat);
    chk({tag, ".n_load"},  nld, (x.kind == 2'd1) ? 1 : 0);
    chk({tag, ".n_store"}, nst, (x.kind == 2'd2) ? 1 : 0);
    chk({tag, ".exc"},   {31'd0, resp_exc},   {31'd0, x.exc});
    chk({tag, ".cause"}, {28'd0, resp_cause}, {28'd0, x.cause});
    chk({tag, ".rd"},    {27'd0, resp_rd},    {27'd0, x.rd});
    chk({tag, ".data"},  resp_data, x.data);
    @(negedge clk);
    chk({tag, ".pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'd0; req_base = 32'd0; req_offset = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.ready",      {31'd0, req_ready},  32'd1);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_exc",   {31'd0, resp_exc},   32'd0);
    chk("rst.resp_cause", {28'd0, resp_cause}, 32'd0);
    chk("rst.resp_rd",    {27'd0, resp_rd},    32'd0);
    chk("rst.resp_data",  resp_data,  32'd0);
    chk("rst.ram_addr",   ram_addr,   32'd0);
    chk("rst.ram_access", {29'd0, ram_access}, 32'd0);
    chk("rst.ram_wdata",  ram_wdata,  32'd0);
    chk("rst.strobes",    {30'd0, ram_load, ram_store}, 32'd0);

    // Word store then load back.
    run_req("sw104", 1'b0, 1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd0,
            e_store(32'h104));
    run_req("lw104", 1'b1, 1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd7,
            e_load(32'h104, 5'd7, 32'hDEADBEEF));

    // Byte store, signed and unsigned byte loads (one via negative offset).
    run_req("sb200",  1'b0, 1'b1, 3'b000, 32'h200, 32'h0, 32'h00000080, 5'd0,
            e_store(32'h200));
    run_req("lb200",  1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 32'h0, 5'd3,
            e_load(32'h200, 5'd3, 32'hFFFFFF80));
    run_req("lbu200", 1'b1, 1'b0, 3'b100, 32'h208, 32'hFFFFFFF8, 32'h0, 5'd4,
            e_load(32'h200, 5'd4, 32'h00000080));

    // Misaligned.
    run_req("lw102", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 5'd6,
            e_fault(4'd4, 32'h102));
    run_req("sh3",   1'b0, 1'b1, 3'b001, 32'h1, 32'h2, 32'h0, 5'd0,
            e_fault(4'd6, 32'h3));

    // Range edges.
    run_req("lw1000", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 5'd1,
            e_fault(4'd5, 32'h1000));
    run_req("swffc",  1'b0, 1'b1, 3'b010, 32'hFF0, 32'hC, 32'hA5A55A5A, 5'd0,
            e_store(32'hFFC));
    run_req("lwffc",  1'b1, 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0, 5'd9,
            e_load(32'hFFC, 5'd9, 32'hA5A55A5A));
    run_req("sbfff",  1'b0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0,
            e_fault(4'd7, 32'hFFFFFFFF));

    // Wrapping effective address is legal.
    run_req("swwrap", 1'b0, 1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, 5'd0,
            e_store(32'h4));
    run_req("lhu6",   1'b1, 1'b0, 3'b101, 32'h6, 32'h0, 32'h0, 5'd12,
            e_load(32'h6, 5'd12, 32'h0000CAFE));

    // Illegal encodings, including illegal over misaligned.
    run_req("ld011", 1'b1, 1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 5'd2,
            e_fault(4'd2, 32'h8));
    run_req("both",  1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 5'd2,
            e_fault(4'd2, 32'h40));
    run_req("ld110", 1'b1, 1'b0, 3'b110, 32'h0, 32'h1, 32'h0, 5'd2,
            e_fault(4'd2, 32'h1));
    run_req("sw_f4", 1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 5'd0,
            e_fault(4'd2, 32'h10));

    // Reset during WAIT of a load: no response.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h100; req_offset = 32'h4; req_rd = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwait.ram_load", {31'd0, ram_load}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait.ready", {31'd0, req_ready}, 32'd1);
    chk("rstwait.rv0",   {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rstwait.rv1",   {31'd0, resp_valid}, 32'd0);

    // Reset during ISSUE of a store: strobe suppressed, memory untouched.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h100; req_offset = 32'h4; req_wdata = 32'h0BADF00D;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstissue.ram_store", {31'd0, ram_store}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstissue.ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rstissue.rv", {31'd0, resp_valid}, 32'd0);
    run_req("lw104b", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5'd11,
            e_load(32'h104, 5'd11, 32'hDEADBEEF));

    // req_valid held through a busy period: latched only in IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h100; req_offset = 32'h4; req_wdata = 32'h11111111; req_rd = 5'd0;
    @(negedge clk);
    chk("hold.c1.store", {31'd0, ram_store}, 32'd1);
    chk("hold.c1.ready", {31'd0, req_ready}, 32'd0);
    req_base = 32'h300; req_wdata = 32'h22222222;
    @(negedge clk);
    chk("hold.c2.rv",    {31'd0, resp_valid}, 32'd1);
    chk("hold.c2.ready", {31'd0, req_ready}, 32'd0);
    chk("hold.c2.addr",  ram_addr, 32'h104);
    chk("hold.c2.wdata", ram_wdata, 32'h11111111);
    chk("hold.c2.store", {31'd0, ram_store}, 32'd0);
    @(negedge clk);
    chk("hold.c3.ready", {31'd0, req_ready}, 32'd1);
    chk("hold.c3.addr",  ram_addr, 32'h104);
    @(negedge clk);
    chk("hold.c4.store", {31'd0, ram_store}, 32'd1);
    chk("hold.c4.addr",  ram_addr, 32'h304);
    chk("hold.c4.wdata", ram_wdata, 32'h22222222);
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold.c5.rv", {31'd0, resp_valid}, 32'd1);
    run_req("lw304", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 5'd13,
            e_load(32'h304, 5'd13, 32'h22222222));

    chk("sb.empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
